// File: rtl/hilo_div_if.sv
// Controller-to-divider handshake: operands and control out, results and status back.
interface hilo_div_if;
  logic        d_en;
  logic        d_sign;
  logic        d_cancel;
  logic [31:0] d_A;
  logic [31:0] d_B;
  logic [31:0] d_Q;
  logic [31:0] d_R;
  logic        d_working;
  logic        d_finish;

  modport master (
    output d_en, d_sign, d_cancel, d_A, d_B,
    input  d_Q, d_R, d_working, d_finish
  );

  modport slave (
    input  d_en, d_sign, d_cancel, d_A, d_B,
    output d_Q, d_R, d_working, d_finish
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO register file and iterative-divider sequencer with flush, mt writes and watchdog abort.
// state | meaning
// IDLE  | no divide in flight; mthi/mtlo accepted; a request issues d_en
// RUN   | divider working; wait for d_finish, flush or watchdog
module hilo_div_ctrl #(
  parameter int          TIMEOUT  = 31,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_req,
  input  logic        div_sign,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        flush,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  input  logic        hilo_rd,
  hilo_div_if.master  dv,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        tmo_err
);

  localparam int CW = ($clog2(TIMEOUT + 1) < 5) ? 5 : $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        run;
  logic        issue;
  logic        timeout;
  logic        unused_ok;

  // Gating with resetn keeps every control output low while reset is held.
  assign run     = resetn && (state == RUN);
  assign issue   = resetn && (state == IDLE) && div_req && !flush;
  assign timeout = run && !flush && !dv.d_finish && (cnt == CW'(TIMEOUT));

  assign dv.d_en     = issue;
  assign dv.d_sign   = issue & div_sign;
  assign dv.d_A      = issue ? div_a : 32'h0;
  assign dv.d_B      = issue ? div_b : 32'h0;
  assign dv.d_cancel = run && (flush || timeout);

  assign stall_o = issue | (run & ~dv.d_finish & ~flush & ~timeout);
  assign busy_o  = run;
  assign tmo_err = timeout;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  // Reads never wait on the FSM; divider busy status is informational only.
  assign unused_ok = ^{hilo_rd, dv.d_working};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= HILO_RST;
      lo_q  <= HILO_RST;
    end else begin
      case (state)
        IDLE: begin
          if (!flush) begin
            if (mthi_we) hi_q <= mt_data;
            if (mtlo_we) lo_q <= mt_data;
            if (div_req) begin
              state <= RUN;
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          // Flush beats finish, finish beats the watchdog.
          if (flush || timeout) begin
            state <= IDLE;
          end else if (dv.d_finish) begin
            lo_q  <= dv.d_Q;
            hi_q  <= dv.d_R;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
